// File: rtl/serial_subtractor_seq.sv
// serial_subtractor_seq: bit-serial a - b - bin, LSB first, start/busy/done handshake.
// Define OVF_FLAG_EN to add the two's-complement overflow flag output ovf.
module serial_subtractor_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] sa, sb;
  logic br, diff, br_n;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign diff = sa[0] ^ sb[0] ^ br;
  assign br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
`ifdef OVF_FLAG_EN
  logic am, bm;
`endif
  // sa doubles as the result register: difference bits enter at the MSB as minuend bits leave the LSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else if (state != RUN && start) begin
      state <= RUN;
      sa    <= a;
      sb    <= b;
      br    <= bin;
      count <= '0;
`ifdef OVF_FLAG_EN
      am    <= a[WIDTH-1];
      bm    <= b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      sa    <= {diff, sa[WIDTH-1:1]};
      sb    <= sb >> 1;
      br    <= br_n;
      count <= count + 1'b1;
      if (count == LAST) begin
        state <= DONE;
        d     <= {diff, sa[WIDTH-1:1]};
        bout  <= br_n;
`ifdef OVF_FLAG_EN
        ovf   <= (am != bm) && (diff != am);
`endif
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor_seq.sv
// tb_serial_subtractor_seq: directed and random checks against an arithmetic reference model.
module tb_serial_subtractor_seq;
  localparam int W = 5;
  logic clk = 0, rst_n = 0, start = 0, bin = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, bout;
  logic [W-1:0] d;
`ifdef OVF_FLAG_EN
  logic ovf;
`endif
  int errors = 0, checks = 0;
  serial_subtractor_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin, input bit poke);
    int n, nb;
    logic [W:0] m;
    a = xa; b = xb; bin = xbin; start = 1;
    tick();
    start = 0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      if (poke && n == 2) begin start = 1; a = 1; b = 1; end else start = 0;
      tick();
      n++;
    end
    start = 0;
    m = {1'b0, xa} - {1'b0, xb} - (W+1)'(xbin);
    chk("latency", n, W);
    chk("busy_cycles", nb, W);
    chk("done_busy", busy, 0);
    chk("d", d, m[W-1:0]);
    chk("bout", bout, m[W]);
`ifdef OVF_FLAG_EN
    chk("ovf", ovf, (xa[W-1] != xb[W-1]) && (m[W-1] != xa[W-1]));
`endif
    tick();
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    int n, nd;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1;
    tick();
    op(5'd9, 5'd3, 1'b0, 0);
    chk("dir_9_3", d, 6);
    op(5'd3, 5'd9, 1'b0, 0);
    chk("dir_3_9", d, 26);
    op(5'd0, 5'd0, 1'b1, 0);
    chk("dir_wrap", d, 31);
    op(5'd20, 5'd4, 1'b0, 1);
    chk("ignored_start", d, 16);
    // abort in the third RUN cycle
    a = 9; b = 3; bin = 0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_bout", bout, 0);
    nd = 0;
    repeat (8) begin
      if (done) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    op(5'd9, 5'd3, 1'b0, 0);
    // start held high: 9-3 then 3-9 back to back
    a = 9; b = 3; bin = 0; start = 1;
    tick();
    a = 3; b = 9;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("b2b_lat", n, W);
    chk("b2b_d1", d, 6);
    chk("b2b_bout1", bout, 0);
    n = 0;
    do begin tick(); n++; end while (!done && n < 20);
    chk("b2b_gap", n, W + 1);
    chk("b2b_d2", d, 26);
    chk("b2b_bout2", bout, 1);
    start = 0;
    tick();
    chk("b2b_end", done, 0);
`ifdef OVF_FLAG_EN
    op(5'd15, 5'd16, 1'b0, 0);
    chk("ovf_set", ovf, 1);
    op(5'd5, 5'd3, 1'b0, 0);
    chk("ovf_clr", ovf, 0);
`endif
    repeat (25) op(W'($urandom), W'($urandom), 1'($urandom), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
